// File: rtl/mips_multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_pkg
// Purpose  : Shared encodings for the multicycle MIPS control unit: ALU
//            operation codes, opcode/funct values, ALUOp and FSM state enums.
// Revision : 1.0 - initial release
// ============================================================================
package mips_multicycle_ctrl_pkg;

  // ALU operation codes driven onto the ALU's ALUcont input
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALUOp: what the FSM asks of the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Control FSM states; the four unused encodings recover to S_FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage : mips_multicycle_ctrl_pkg
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_alu_decoder
// Purpose  : Combinational ALU decoder, (ALUOp, funct) -> ALUcont.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl_alu_decoder
  import mips_multicycle_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);

  // ADD/SUB requests pass straight through; FUNCT defers to the R-type field
  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucont = ALU_ADD;
          FUNCT_SUB: alucont = ALU_SUB;
          FUNCT_AND: alucont = ALU_AND;
          FUNCT_OR:  alucont = ALU_OR;
          FUNCT_SLT: alucont = ALU_SLT;
          default:   alucont = ALU_ADD;
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule : mips_multicycle_ctrl_alu_decoder
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Multicycle MIPS control unit. Moore FSM sequencing fetch,
//            decode and execute steps, plus ALU decode and PC enable logic.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALUcont
);

  state_t r_state;
  state_t w_next;
  state_t w_dec_state;

  logic   w_memwrite;
  logic   w_irwrite;
  logic   w_regwrite;
  logic   w_pcwrite;
  logic   w_branch;
  aluop_t w_aluop;

  // State register; reset returns to FETCH, aborting any instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; unused encodings fall through to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = S_FETCH;
      S_EXECUTE: w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // While reset is high the selects show their FETCH values
  assign w_dec_state = reset ? S_FETCH : r_state;

  // Moore output decode from the effective state
  always_comb begin
    IorD       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    w_regwrite = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_aluop    = ALUOP_ADD;
    case (w_dec_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_aluop  = ALUOP_SUB;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: begin
        ALUSrcB = 2'b00;
      end
    endcase
  end

  // Architectural write enables are held off for the whole reset
  assign MemWrite = w_memwrite & ~reset;
  assign IRWrite  = w_irwrite  & ~reset;
  assign RegWrite = w_regwrite & ~reset;
  assign PCEn     = (w_pcwrite | (w_branch & zero)) & ~reset;

  mips_multicycle_ctrl_alu_decoder u_alu_decoder (
    .aluop   (w_aluop),
    .funct   (funct),
    .alucont (ALUcont)
  );

endmodule : mips_multicycle_ctrl
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Purpose  : Directed self-checking bench for mips_multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUcont;

  int n_checks = 0;
  int n_errors = 0;

  // Packed output view: {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,
  //                      ALUSrcA,ALUSrcB,PCSrc,PCEn,ALUcont}
  typedef struct {
    logic [14:0] exp;
    string       tag;
  } sb_item_t;

  sb_item_t sb[$];

  mips_multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .IorD     (IorD),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .PCSrc    (PCSrc),
    .PCEn     (PCEn),
    .ALUcont  (ALUcont)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ev(input logic iord, input logic mw, input logic irw,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic sa, input logic [1:0] sb_sel,
                                     input logic [1:0] pcs, input logic pcen,
                                     input logic [2:0] ac);
    return {iord, mw, irw, rd, m2r, rw, sa, sb_sel, pcs, pcen, ac};
  endfunction

  // Expected outputs per state, written straight from the state table
  logic [14:0] e_rst, e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr;
  logic [14:0] e_aluwb, e_addiwb, e_jump;

  function automatic logic [14:0] e_execute(input logic [2:0] ac);
    return ev(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, ac);
  endfunction

  function automatic logic [14:0] e_branch(input logic z);
    return ev(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, z, ALU_SUB);
  endfunction

  // Checker: outputs are sampled mid-cycle, one scoreboard entry per cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_item_t it;
      logic [14:0] obs;
      it  = sb.pop_front();
      obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, PCSrc, PCEn, ALUcont};
      n_checks++;
      assert (obs === it.exp) else begin
        n_errors++;
        $error("FAIL %s: observed %b expected %b", it.tag, obs, it.exp);
      end
    end
  end

  // Drive one cycle's inputs just after the edge and queue the expectation
  task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic [14:0] exp, input string tag);
    @(posedge clk);
    #1;
    reset = rst;
    op    = o;
    funct = f;
    zero  = z;
    sb.push_back('{exp: exp, tag: tag});
  endtask

  logic [5:0] rt_funct [5];
  logic [2:0] rt_alu   [5];

  initial begin
    e_rst    = ev(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, ALU_ADD);
    e_fetch  = ev(0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 1, ALU_ADD);
    e_decode = ev(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, ALU_ADD);
    e_memadr = ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, ALU_ADD);
    e_memrd  = ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, ALU_ADD);
    e_memwb  = ev(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, ALU_ADD);
    e_memwr  = ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, ALU_ADD);
    e_aluwb  = ev(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, ALU_ADD);
    e_addiwb = ev(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, ALU_ADD);
    e_jump   = ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, ALU_ADD);

    rt_funct[0] = 6'b100010; rt_alu[0] = ALU_SUB;
    rt_funct[1] = 6'b100100; rt_alu[1] = ALU_AND;
    rt_funct[2] = 6'b100101; rt_alu[2] = ALU_OR;
    rt_funct[3] = 6'b101010; rt_alu[3] = ALU_SLT;
    rt_funct[4] = 6'b100000; rt_alu[4] = ALU_ADD;

    reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0;

    // Reset held two cycles
    step(1, 6'b000000, 6'b000000, 0, e_rst, "reset_c1");
    step(1, 6'b000000, 6'b000000, 0, e_rst, "reset_c2");

    // R-type, each funct in turn
    for (int i = 0; i < 5; i++) begin
      step(0, 6'b000000, rt_funct[i], 0, e_fetch,               "rt_fetch");
      step(0, 6'b000000, rt_funct[i], 0, e_decode,              "rt_decode");
      step(0, 6'b000000, rt_funct[i], 0, e_execute(rt_alu[i]),  "rt_execute");
      step(0, 6'b000000, rt_funct[i], 0, e_aluwb,               "rt_aluwb");
    end

    // lw
    step(0, 6'b100011, 6'b000000, 0, e_fetch,  "lw_fetch");
    step(0, 6'b100011, 6'b000000, 0, e_decode, "lw_decode");
    step(0, 6'b100011, 6'b000000, 0, e_memadr, "lw_memadr");
    step(0, 6'b100011, 6'b000000, 0, e_memrd,  "lw_memrd");
    step(0, 6'b100011, 6'b000000, 0, e_memwb,  "lw_memwb");

    // beq taken; zero high during decode must not leak into PCEn
    step(0, 6'b000100, 6'b000000, 1, e_fetch,     "beq1_fetch");
    step(0, 6'b000100, 6'b000000, 1, e_decode,    "beq1_decode");
    step(0, 6'b000100, 6'b000000, 1, e_branch(1), "beq1_branch");
    // beq not taken
    step(0, 6'b000100, 6'b000000, 0, e_fetch,     "beq0_fetch");
    step(0, 6'b000100, 6'b000000, 0, e_decode,    "beq0_decode");
    step(0, 6'b000100, 6'b000000, 0, e_branch(0), "beq0_branch");

    // sw
    step(0, 6'b101011, 6'b000000, 0, e_fetch,  "sw_fetch");
    step(0, 6'b101011, 6'b000000, 0, e_decode, "sw_decode");
    step(0, 6'b101011, 6'b000000, 0, e_memadr, "sw_memadr");
    step(0, 6'b101011, 6'b000000, 0, e_memwr,  "sw_memwr");

    // addi
    step(0, 6'b001000, 6'b000000, 0, e_fetch,  "addi_fetch");
    step(0, 6'b001000, 6'b000000, 0, e_decode, "addi_decode");
    step(0, 6'b001000, 6'b000000, 0, e_memadr, "addi_ex");
    step(0, 6'b001000, 6'b000000, 0, e_addiwb, "addi_wb");

    // j
    step(0, 6'b000010, 6'b000000, 0, e_fetch,  "j_fetch");
    step(0, 6'b000010, 6'b000000, 0, e_decode, "j_decode");
    step(0, 6'b000010, 6'b000000, 0, e_jump,   "j_jump");

    // unknown opcode behaves as a two-cycle nop
    step(0, 6'b111111, 6'b000000, 0, e_fetch,  "unk_fetch");
    step(0, 6'b111111, 6'b000000, 0, e_decode, "unk_decode");

    // sw aborted by reset in MEMWR
    step(0, 6'b101011, 6'b000000, 0, e_fetch,  "swr_fetch");
    step(0, 6'b101011, 6'b000000, 0, e_decode, "swr_decode");
    step(0, 6'b101011, 6'b000000, 0, e_memadr, "swr_memadr");
    step(1, 6'b101011, 6'b000000, 0, e_rst,    "swr_reset_in_memwr");
    step(0, 6'b101011, 6'b000000, 0, e_fetch,  "swr_after_reset");
    step(0, 6'b101011, 6'b000000, 0, e_decode, "swr_decode2");

    // Let the checker drain the queue, bounded
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: observed %0d pending entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mips_multicycle_ctrl
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Control unit for the multicycle MIPS datapath; sits directly upstream of the ALU and drives its 3-bit ALUcont input plus all datapath mux selects and write enables. A Moore FSM sequences each instruction through fetch, decode and execute steps. A combinational ALU decoder maps the FSM's ALUOp and the instruction funct field onto the shared ALU_* codes. The ALU zero flag feeds back to resolve beq.

Parameters:
none (encodings come from the shared package / common.svh)

Ports:
clk       input   1  rising-edge clock
reset     input   1  synchronous, active-high
op        input   6  instr[31:26] from instruction register
funct     input   6  instr[5:0] from instruction register
zero      input   1  ALU zero flag (same-cycle, combinational)
IorD      output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write enable
IRWrite   output  1  instruction register load enable
RegDst    output  1  write register: 0=rt, 1=rd
MemtoReg  output  1  write data: 0=ALUOut, 1=Data
RegWrite  output  1  register file write enable
ALUSrcA   output  1  0=PC, 1=regA
ALUSrcB   output  2  00=regB, 01=const 4, 10=SignImm, 11=SignImm<<2
PCSrc     output  2  00=ALUResult, 01=ALUOut, 10=jump target
PCEn      output  1  PC load enable
ALUcont   output  3  ALU operation, ALU_* code

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high. On a reset edge the state becomes FETCH.
- Outputs during reset: while reset=1, MemWrite, IRWrite, RegWrite and PCEn are forced to 0. All other outputs take their FETCH values. A reset mid-instruction aborts the instruction with no partial write.
- Output timing: outputs are decoded from state only; ALUcont additionally uses funct; PCEn additionally uses zero. No output is registered.
- PCEn = PCWrite | (Branch & zero).
- Instruction opcodes: lw=100011, sw=101011, R-type=000000, beq=000100, addi=001000, j=000010.
- ALUOp decode:
  - 00 -> ALU_ADD
  - 01 -> ALU_SUB
  - 10 -> decode funct: add 100000 -> ALU_ADD; sub 100010 -> ALU_SUB; and 100100 -> ALU_AND; or 100101 -> ALU_OR; slt 101010 -> ALU_SLT; any other funct -> ALU_ADD.
- States and per-state outputs. All unlisted enables are 0 and unlisted selects are 0.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1 -> DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next state:
    - lw or sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - any other op -> FETCH (treated as a nop; no write of any kind).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD if lw, MEMWR if sw.
  - MEMRD: IorD=1 -> MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR: IorD=1, MemWrite=1 -> FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- Illegal state encodings go to FETCH on the next edge.
- Cycle counts per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.

Decomposition:
- Shared package (with common.svh): the ALU_* codes, opcode and funct localparams, the ALUOp enum (ADD/SUB/FUNCT), and the state enum.
- The u1/u2/u3/u6 typedefs stay in common.svh.
- One sub-module, alu_decoder: combinational, (ALUOp, funct) -> ALUcont.
- The FSM, output decode and PCEn logic live in the top module.

Test Plan:
- Reset held 2 cycles then released, op=000000 -> during reset IRWrite=PCEn=RegWrite=MemWrite=0. First cycle after release: IRWrite=1, PCEn=1, ALUSrcB=01, ALUcont=ALU_ADD.
- op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. IorD=1 in MEMRD. RegWrite=1 and MemtoReg=1 only in cycle 5.
- op=000000 with funct=100010, 100100, 100101, 101010, 100000 in turn -> ALUcont in EXECUTE is ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_ADD. RegWrite=1 and RegDst=1 in ALUWB.
- op=000100 (beq): zero=1 in BRANCH -> PCEn=1, PCSrc=01, ALUcont=ALU_SUB. Repeat with zero=0 -> PCEn=0. Both return to FETCH after 3 cycles.
- op=101011 (sw) -> MemWrite=1 exactly once, in cycle 4, RegWrite never asserted. op=000010 (j) -> PCSrc=10 and PCEn=1 in cycle 3.
- Unknown op=111111 -> DECODE then FETCH, no RegWrite or MemWrite. Reset asserted during MEMWR (MemWrite would be 1) -> MemWrite=0 that cycle, and state is FETCH on the next edge.
